id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that feeds the ALU operand ports (R2, R3, ALUOp) in the EX stage.
- Latches the decoded instruction and register-file operands each cycle, and supports stall (hold) and flush (bubble).
- Resolves read-after-write data hazards against the instruction in WB, so the ALU always sees current operand values.
- Downstream consumer: the ALU, via ex_r2 to ALU_R2, ex_r3 to ALU_R3 and ex_alu_op to ALU_ALUOP.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width. Register 0 reads as zero and is never forwarded.
- OP_W, 3, ALU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_alu_op  in  OP_W  decoded ALU opcode.
- id_rs1_addr  in  REG_AW  source register for R2.
- id_rs2_addr  in  REG_AW  source register for R3.
- id_rd_addr  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_rs1_data  in  DATA_W  register-file read data, port 1.
- id_rs2_data  in  DATA_W  register-file read data, port 2.
- stall  in  1  hold the current EX contents.
- flush  in  1  replace EX contents with a bubble.
- wb_valid  in  1  WB stage holds a real instruction.
- wb_reg_write  in  1  WB instruction writes the register file this cycle.
- wb_rd_addr  in  REG_AW  WB destination register.
- wb_data  in  DATA_W  WB result; the registered ALU_R1.
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_op  out  OP_W  to ALU_ALUOP.
- ex_r2  out  DATA_W  to ALU_R2, forwarded.
- ex_r3  out  DATA_W  to ALU_R3, forwarded.
- ex_rd_addr  out  REG_AW  destination, passed to EX/WB.
- ex_reg_write  out  1  gated with ex_valid.
- ex_fwd  out  2  bit0 = R2 forwarded, bit1 = R3 forwarded, this cycle. Debug/coverage only.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all registered state is 0, so ex_valid=0, ex_alu_op=0 (MOV), ex_rd_addr=0 and ex_reg_write=0.
  - Stored operands are 0, so ex_r2=ex_r3=0 unless wb forwarding is active.
  - rst overrides stall and flush.
- Latency: ID fields appear at the EX outputs 1 cycle after capture.
- Define wb_hit(a) = wb_valid & wb_reg_write & (wb_rd_addr == a) & (a != 0).
- Update priority each clock: rst > flush > stall > load.
- Flush: ex_valid=0, ex_reg_write=0, ex_alu_op=0, ex_rd_addr=0. Stored operands and source addresses are cleared to 0.
- Stall:
  - All fields hold.
  - Exception: if wb_hit(stored rs1) then stored R2 <= wb_data; likewise R3 with rs2.
  - This prevents the value going stale once the producer leaves WB.
- Load (neither stall nor flush):
  - Capture all ID fields.
  - Capture-time bypass: the register file has no write-through, so if wb_hit(id_rs1_addr), stored R2 <= wb_data instead of id_rs1_data. Same for R3 with rs2.
  - ex_valid <= id_valid.
  - ex_reg_write <= id_reg_write & id_valid.
- Output-time forwarding (combinational, same cycle):
  - ex_r2 = wb_hit(stored rs1) ? wb_data : stored R2. Same for ex_r3 with rs2.
  - ex_fwd reflects the selects.
  - Applies only when ex_valid=1. A bubble never selects wb_data.
- Address 0: stored value comes from id data, which the register file returns as 0. It is never forwarded, even if WB writes rd=0.
- stall and flush together: flush wins.
- Forwarding ignores opcode: it applies regardless of whether the ALU uses R3 (MOV, NOT). This is harmless.
- Widths: all data paths are DATA_W. No arithmetic is performed in this block.

Decomposition:
- Shared package:
  - ALU opcode constants: ALU_MOV=0, ALU_NOT=1, ALU_AND=2, ALU_ADD=3, ALU_NOR=4, ALU_NAND=5, ALU_SUB=6, ALU_SLT=7.
  - DATA_W, REG_AW and OP_W defaults.
- Sub-module: fwd_mux, instantiated once per operand.
  - Inputs: address compare, wb qualify, and the 2:1 select.
  - Outputs: data and hit flag.
  - Used for both capture-time and output-time bypass.

Test Plan:
1. Reset then load: id ADD(3), rs1=1 (data 5), rs2=2 (data 12), rd=3, valid; no WB write. Next cycle: ex_alu_op=3, ex_r2=5, ex_r3=12, ex_reg_write=1, ex_fwd=00.
2. Output forward: EX holds rs1=3 (stored 0). WB writes rd=3, data 17. Same cycle: ex_r2=17, ex_fwd[0]=1. With wb_rd_addr=0 or wb_valid=0: ex_r2=0, ex_fwd=00.
3. Capture bypass: id rs2=4 (stale data 7) while WB writes r4=99. Next cycle with WB idle: ex_r3=99.
4. Stall refresh: stall=1 for 3 cycles with EX rs1=5 (stored 1). WB writes r5=0xFFFFFFFF in cycle 1, then idles. Cycles 2–3: ex_r2=0xFFFFFFFF, and all other fields unchanged.
5. Flush vs stall: stall=1 and flush=1 together. Next cycle: ex_valid=0, ex_reg_write=0, ex_alu_op=0. WB write to r1=8 with a stored rs1 of 0 does not forward.
6. Mid-stream reset: rst=1 for 1 cycle during a stalled SUB(6). Next cycle: all outputs 0, and a following load is captured normally.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths and ALU opcodes.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [OP_W_DEF-1:0] {
        ALU_MOV  = 3'd0,
        ALU_NOT  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_NOR  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_SUB  = 3'd6,
        ALU_SLT  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// WB bypass select for one operand: picks wb_data when WB is writing the source register.
import id_ex_stage_pkg::*;

module id_ex_stage_fwd_mux #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              en,
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] out_data,
    output logic              hit
);

    always_comb begin
        // r0 is hard-wired to zero, so a WB write to it must never be bypassed
        hit      = en & wb_valid & wb_reg_write
                   & (wb_rd_addr == src_addr) & (src_addr != '0);
        out_data = hit ? wb_data : src_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall/flush and WB-to-EX operand bypass.
import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0] ex_r2,
    output logic [DATA_W-1:0] ex_r3,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic [1:0]        ex_fwd
);

    logic              valid_q,     valid_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic [REG_AW-1:0] rs1_q,       rs1_d;
    logic [REG_AW-1:0] rs2_q,       rs2_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] r2_q,        r2_d;
    logic [DATA_W-1:0] r3_q,        r3_d;

    logic [DATA_W-1:0] cap_r2, cap_r3, cur_r2, cur_r3;
    logic              cap_hit2, cap_hit3, cur_hit2, cur_hit3;

    // Capture-time bypass: the register file does not write through
    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_r2 (
        .en(1'b1), .src_addr(id_rs1_addr), .src_data(id_rs1_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_data(cap_r2), .hit(cap_hit2)
    );

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_r3 (
        .en(1'b1), .src_addr(id_rs2_addr), .src_data(id_rs2_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_data(cap_r3), .hit(cap_hit3)
    );

    // Bypass against the held operands; drives both the stall refresh and the EX outputs
    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cur_r2 (
        .en(1'b1), .src_addr(rs1_q), .src_data(r2_q),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_data(cur_r2), .hit(cur_hit2)
    );

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cur_r3 (
        .en(1'b1), .src_addr(rs2_q), .src_data(r3_q),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_data(cur_r3), .hit(cur_hit3)
    );

    logic unused_cap_hits;
    assign unused_cap_hits = cap_hit2 | cap_hit3;

    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        if (flush) begin
            valid_d     = 1'b0;
            alu_op_d    = OP_W'(ALU_MOV);
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
            r2_d        = '0;
            r3_d        = '0;
        end else if (stall) begin
            // Keep held operands current so they do not go stale once WB moves on
            r2_d = cur_r2;
            r3_d = cur_r3;
        end else begin
            valid_d     = id_valid;
            alu_op_d    = id_alu_op;
            rs1_d       = id_rs1_addr;
            rs2_d       = id_rs2_addr;
            rd_d        = id_rd_addr;
            reg_write_d = id_reg_write & id_valid;
            r2_d        = cap_r2;
            r3_d        = cap_r3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_op_q    <= OP_W'(ALU_MOV);
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            r2_q        <= '0;
            r3_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
        end
    end

    // A bubble never picks up wb_data at the ALU ports
    always_comb begin
        ex_valid     = valid_q;
        ex_alu_op    = alu_op_q;
        ex_rd_addr   = rd_q;
        ex_reg_write = reg_write_q & valid_q;
        ex_r2        = valid_q ? cur_r2 : r2_q;
        ex_r3        = valid_q ? cur_r3 : r3_q;
        ex_fwd       = {valid_q & cur_hit3, valid_q & cur_hit2};
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference is an architectural register file plus the EX instruction fields.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 3;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [OW-1:0] id_alu_op;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic          id_reg_write;
    logic [DW-1:0] id_rs1_data, id_rs2_data;
    logic          stall, flush;
    logic          wb_valid, wb_reg_write;
    logic [AW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_data;
    logic          ex_valid;
    logic [OW-1:0] ex_alu_op;
    logic [DW-1:0] ex_r2, ex_r3;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_reg_write;
    logic [1:0]    ex_fwd;

    int n_vec = 0;
    int n_bad = 0;

    // Architectural register file (committed values) and the instruction held in EX
    logic [DW-1:0] rf [32];
    logic          m_valid, m_rw;
    logic [OW-1:0] m_op;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_r2(ex_r2), .ex_r3(ex_r3),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_fwd(ex_fwd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic wb_writes(input logic [AW-1:0] a);
        return wb_valid && wb_reg_write && (wb_rd_addr == a) && (a != '0);
    endfunction

    // The ALU must see the newest value of each source: this cycle's WB result if WB targets it,
    // otherwise the committed register. A bubble shows the committed value without bypass.
    task automatic check_model(input string tag);
        logic f1, f2;
        logic [DW-1:0] e2, e3;
        #1;
        f1 = m_valid && wb_writes(m_rs1);
        f2 = m_valid && wb_writes(m_rs2);
        e2 = f1 ? wb_data : rf[m_rs1];
        e3 = f2 ? wb_data : rf[m_rs2];
        chk({tag, ".valid"}, DW'(ex_valid), DW'(m_valid));
        chk({tag, ".op"},    DW'(ex_alu_op), DW'(m_op));
        chk({tag, ".rd"},    DW'(ex_rd_addr), DW'(m_rd));
        chk({tag, ".rw"},    DW'(ex_reg_write), DW'(m_rw));
        chk({tag, ".r2"},    ex_r2, e2);
        chk({tag, ".r3"},    ex_r3, e3);
        chk({tag, ".fwd"},   DW'(ex_fwd), DW'({f2, f1}));
    endtask

    task automatic model_update();
        if (rst || flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_op = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        end else if (!stall) begin
            m_valid = id_valid;
            m_rw    = id_valid && id_reg_write;
            m_op    = id_alu_op;
            m_rs1   = id_rs1_addr;
            m_rs2   = id_rs2_addr;
            m_rd    = id_rd_addr;
        end
        if (wb_writes(wb_rd_addr)) rf[wb_rd_addr] = wb_data;
    endtask

    // Register file read data always reflects committed state (no write-through)
    task automatic tick();
        id_rs1_data = rf[id_rs1_addr];
        id_rs2_data = rf[id_rs2_addr];
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] rd, input logic rw);
        id_valid = v; id_alu_op = op; id_rs1_addr = a1; id_rs2_addr = a2;
        id_rd_addr = rd; id_reg_write = rw;
    endtask

    task automatic set_wb(input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid = v; wb_reg_write = rw; wb_rd_addr = a; wb_data = d;
    endtask

    task automatic wb_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_wb(1'b1, 1'b1, a, d);
        check_model("preload");
        tick();
        set_wb(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        m_valid = 1'b0; m_rw = 1'b0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        set_id(1'b0, '0, '0, '0, '0, 1'b0);
        id_rs1_data = '0; id_rs2_data = '0;
        set_wb(1'b0, 1'b0, '0, '0);
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        @(negedge clk);
        tick();
        #1;
        chk("rst.valid", DW'(ex_valid), 0);
        chk("rst.op",    DW'(ex_alu_op), 0);
        chk("rst.r2",    ex_r2, 0);
        chk("rst.r3",    ex_r3, 0);
        chk("rst.rd",    DW'(ex_rd_addr), 0);
        chk("rst.rw",    DW'(ex_reg_write), 0);
        check_model("rst");
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        wb_wr(5'd1, 32'd5);
        wb_wr(5'd2, 32'd12);
        wb_wr(5'd4, 32'd7);
        wb_wr(5'd5, 32'd1);

        // 1: plain load
        set_id(1'b1, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        check_model("t1_pre");
        tick();
        stall = 1'b1;
        #1;
        chk("t1.op",  DW'(ex_alu_op), 3);
        chk("t1.r2",  ex_r2, 5);
        chk("t1.r3",  ex_r3, 12);
        chk("t1.rw",  DW'(ex_reg_write), 1);
        chk("t1.fwd", DW'(ex_fwd), 0);
        check_model("t1");

        // 2: output-time forwarding and its qualifiers
        stall = 1'b0;
        set_id(1'b1, ALU_AND, 5'd3, 5'd2, 5'd6, 1'b1);
        tick();
        stall = 1'b1;
        set_wb(1'b1, 1'b1, 5'd3, 32'd17);
        #1;
        chk("t2.r2",  ex_r2, 17);
        chk("t2.fwd", DW'(ex_fwd), 1);
        check_model("t2_hit");
        wb_rd_addr = 5'd0;
        #1;
        chk("t2_r0.r2",  ex_r2, 0);
        chk("t2_r0.fwd", DW'(ex_fwd), 0);
        check_model("t2_r0");
        wb_rd_addr = 5'd3; wb_valid = 1'b0;
        #1;
        chk("t2_nv.r2",  ex_r2, 0);
        chk("t2_nv.fwd", DW'(ex_fwd), 0);
        check_model("t2_nv");
        set_wb(1'b0, 1'b0, '0, '0);
        tick();

        // 3: capture-time bypass over stale register data
        stall = 1'b0;
        set_id(1'b1, ALU_SUB, 5'd0, 5'd4, 5'd7, 1'b1);
        set_wb(1'b1, 1'b1, 5'd4, 32'd99);
        check_model("t3_pre");
        tick();
        set_wb(1'b0, 1'b0, '0, '0);
        stall = 1'b1;
        #1;
        chk("t3.r3", ex_r3, 99);
        chk("t3.r2", ex_r2, 0);
        check_model("t3");

        // 4: stall refresh
        stall = 1'b0;
        set_id(1'b1, ALU_NOR, 5'd5, 5'd1, 5'd2, 1'b1);
        check_model("t4_pre");
        tick();
        stall = 1'b1;
        set_wb(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF);
        check_model("t4_c1");
        tick();
        set_wb(1'b0, 1'b0, '0, '0);
        for (int c = 2; c <= 3; c++) begin
            #1;
            chk("t4.r2",    ex_r2, 32'hFFFF_FFFF);
            chk("t4.r3",    ex_r3, 5);
            chk("t4.op",    DW'(ex_alu_op), 4);
            chk("t4.rd",    DW'(ex_rd_addr), 2);
            chk("t4.valid", DW'(ex_valid), 1);
            chk("t4.rw",    DW'(ex_reg_write), 1);
            chk("t4.fwd",   DW'(ex_fwd), 0);
            check_model("t4_hold");
            tick();
        end

        // 5: flush wins over stall, bubble never forwards
        stall = 1'b1; flush = 1'b1;
        check_model("t5_pre");
        tick();
        flush = 1'b0;
        set_wb(1'b1, 1'b1, 5'd1, 32'd8);
        #1;
        chk("t5.valid", DW'(ex_valid), 0);
        chk("t5.rw",    DW'(ex_reg_write), 0);
        chk("t5.op",    DW'(ex_alu_op), 0);
        chk("t5.r2",    ex_r2, 0);
        chk("t5.fwd",   DW'(ex_fwd), 0);
        check_model("t5");
        tick();
        set_wb(1'b0, 1'b0, '0, '0);

        // 6: reset during a stalled SUB, then normal load
        stall = 1'b0;
        set_id(1'b1, ALU_SUB, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        stall = 1'b1; rst = 1'b1;
        #1;
        chk("t6_pre.op", DW'(ex_alu_op), 6);
        chk("t6_pre.r2", ex_r2, 8);
        check_model("t6_pre");
        tick();
        rst = 1'b0; stall = 1'b0;
        set_id(1'b1, ALU_AND, 5'd2, 5'd1, 5'd5, 1'b1);
        #1;
        chk("t6.valid", DW'(ex_valid), 0);
        chk("t6.op",    DW'(ex_alu_op), 0);
        chk("t6.r2",    ex_r2, 0);
        chk("t6.r3",    ex_r3, 0);
        chk("t6.rd",    DW'(ex_rd_addr), 0);
        chk("t6.rw",    DW'(ex_reg_write), 0);
        check_model("t6");
        tick();
        set_id(1'b0, '0, '0, '0, '0, 1'b0);
        stall = 1'b1;
        #1;
        chk("t6_ld.valid", DW'(ex_valid), 1);
        chk("t6_ld.op",    DW'(ex_alu_op), 2);
        chk("t6_ld.r2",    ex_r2, 12);
        chk("t6_ld.r3",    ex_r3, 8);
        chk("t6_ld.rd",    DW'(ex_rd_addr), 5);
        check_model("t6_ld");
        stall = 1'b0;

        // Randomized traffic on a narrow register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            set_id(1'($urandom_range(0, 1)), OW'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            set_wb(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   AW'($urandom_range(0, 7)), $urandom);
            check_model("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
